// File: rtl/rev_alu_pkg.sv
// Shared types for the bit-serial reversible ALU controller: opcodes, FSM states, width limits.
// No logic; imported by the controller and its shift registers.
package rev_alu_pkg;

    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 32;

    typedef enum logic [1:0] {
        OP_XOR  = 2'b00,
        OP_XNOR = 2'b01,
        OP_ADD  = 2'b10,
        OP_SUB  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_e;

    function automatic logic op_is_arith(input op_e op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/rev_shift_reg.sv
// Right-shift register with parallel load (priority) and serial-in at the MSB.
// Latency: one cycle from load/shift to o_q.
// Backpressure: none; load and shift are caller-qualified enables.
module rev_shift_reg
    import rev_alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_dat,
    input  logic             i_shift,
    input  logic             i_sin,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
        end else if (i_load) begin
            r_q <= i_load_dat;
        end else if (i_shift) begin
            r_q <= {i_sin, r_q[WIDTH-1:1]};
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/rev_serial_alu_ctrl.sv
// Streams operands LSB-first through an external reversible XOR cell and collects XOR/XNOR/ADD/SUB results.
// Latency: accept at cycle 0, out_valid from cycle WIDTH+1; issue interval WIDTH+2 with out_ready high.
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE. Optional: REV_GARBAGE_CHECK_EN.
module rev_serial_alu_ctrl
    import rev_alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [1:0]       in_op,
    output logic             gate_x1,
    output logic             gate_x2,
    input  logic             gate_y1,
    input  logic             gate_y2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_carry,
    output logic             out_err
);

    localparam int CW = $clog2(WIDTH);

    state_e           r_state, w_state_nxt;
    op_e              r_op;
    logic [CW-1:0]    r_cnt;
    logic             r_carry;
    logic [WIDTH-1:0] w_a_q, w_b_q, w_res_q, w_b_eff;
    logic             w_accept, w_shift, w_last, w_bit, w_carry_nxt;

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        w_shift     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                in_ready = rst_n;
                if (in_valid) w_state_nxt = ST_SHIFT;
            end
            ST_SHIFT: begin
                w_shift = 1'b1;
                if (w_last) w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    assign w_accept = in_valid & in_ready;
    assign w_last   = (r_cnt == CW'(WIDTH - 1));
    // SUB is A + ~B + 1: invert B here and seed the carry with 1.
    assign w_b_eff  = (op_e'(in_op) == OP_SUB) ? ~in_b : in_b;
    assign gate_x1  = w_shift & w_a_q[0];
    assign gate_x2  = w_shift & w_b_q[0];

    always_comb begin
        w_bit = gate_y2 ^ r_carry;
        case (r_op)
            OP_XOR:  w_bit = gate_y2;
            OP_XNOR: w_bit = ~gate_y2;
            default: w_bit = gate_y2 ^ r_carry;
        endcase
    end

    assign w_carry_nxt = (w_a_q[0] & w_b_q[0]) | (r_carry & gate_y2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op    <= OP_XOR;
            r_carry <= 1'b0;
            r_cnt   <= '0;
        end else if (w_accept) begin
            r_op    <= op_e'(in_op);
            r_carry <= (op_e'(in_op) == OP_SUB);
            r_cnt   <= '0;
        end else if (w_shift) begin
            r_cnt <= r_cnt + 1'b1;
            if (op_is_arith(r_op)) r_carry <= w_carry_nxt;
        end
    end

    rev_shift_reg #(.WIDTH(WIDTH)) u_sr_a (
        .clk(clk), .rst_n(rst_n), .i_load(w_accept), .i_load_dat(in_a),
        .i_shift(w_shift), .i_sin(1'b0), .o_q(w_a_q)
    );

    rev_shift_reg #(.WIDTH(WIDTH)) u_sr_b (
        .clk(clk), .rst_n(rst_n), .i_load(w_accept), .i_load_dat(w_b_eff),
        .i_shift(w_shift), .i_sin(1'b0), .o_q(w_b_q)
    );

    rev_shift_reg #(.WIDTH(WIDTH)) u_sr_res (
        .clk(clk), .rst_n(rst_n), .i_load(w_accept), .i_load_dat({WIDTH{1'b0}}),
        .i_shift(w_shift), .i_sin(w_bit), .o_q(w_res_q)
    );

    assign out_result = out_valid ? w_res_q : '0;
    assign out_carry  = out_valid & r_carry;

`ifdef REV_GARBAGE_CHECK_EN
    logic r_err;
    logic w_unused;

    // The cell's pass-through output must mirror its input; any difference means the gate leaked garbage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                               r_err <= 1'b0;
        else if (w_accept)                        r_err <= 1'b0;
        else if (w_shift && (gate_y1 != gate_x1)) r_err <= 1'b1;
    end

    assign out_err  = out_valid & r_err;
    assign w_unused = ^{w_a_q[WIDTH-1:1], w_b_q[WIDTH-1:1]};
`else
    logic w_unused;

    assign out_err  = 1'b0;
    assign w_unused = ^{w_a_q[WIDTH-1:1], w_b_q[WIDTH-1:1], gate_y1};
`endif

endmodule
